// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path definitions: NOP encoding, responder FSM states, latency
// counter width and the fetch address legality check.
package rv_fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned LAT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_e;

   // Full 30-bit word-index compare so that high address bits can never
   // alias into the array through truncated indexing.
   function automatic logic word_in_range(input logic [31:0] byte_addr,
                                          input int unsigned depth);
      return byte_addr[31:2] < 30'(depth);
   endfunction

   function automatic logic fetch_fault(input logic [31:0] byte_addr,
                                        input int unsigned depth);
      return (byte_addr[1:0] != 2'b00) || !word_in_range(byte_addr, depth);
   endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, combinational read, and write-first
// bypass when the same word is written and read on one edge. No reset.
module imem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = mem_q[raddr];
      if (we && (waddr == raddr)) begin
         rdata = wdata;
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch interface: accepts a PC fetch, waits LATENCY cycles
// and returns the instruction word with a one-cycle instr_valid pulse.
module imem_responder
   import rv_fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic        req,
   input  logic [31:0] addr,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fault,
   output logic        busy,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   fetch_state_e     state_q;
   logic [LAT_W-1:0] cnt_q;
   logic [31:0]      addr_q;
   logic [31:0]      instr_q;
   logic             valid_q;
   logic             fault_q;
   logic             busy_q;

   logic             wr_we;
   logic [31:0]      rd_data;
   logic             fault_d;
   logic [31:0]      instr_d;
   logic             unused_wr_lsb;

   assign wr_we         = wr_en && word_in_range(wr_addr, DEPTH);
   assign unused_wr_lsb = ^wr_addr[1:0];

   imem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (wr_we),
      .waddr (wr_addr[IDX_W+1:2]),
      .wdata (wr_data),
      .raddr (addr_q[IDX_W+1:2]),
      .rdata (rd_data)
   );

   // A faulting fetch never uses the array data, so truncated indexing is harmless.
   always_comb begin
      fault_d = fetch_fault(addr_q, DEPTH);
      instr_d = fault_d ? NOP_INSTR : rd_data;
   end

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  cnt_q   <= LAT_W'(LATENCY);
                  state_q <= WAIT;
                  busy_q  <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  instr_q <= instr_d;
                  fault_q <= fault_d;
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (req) begin
                  addr_q  <= addr;
                  cnt_q   <= LAT_W'(LATENCY);
                  state_q <= WAIT;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fault       = fault_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed and randomized bench for imem_responder at LATENCY 2, 0 and 5,
// checked against a word-array reference model of the fetch rules.
module tb_imem_responder;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        a_rst;
   logic        req;
   logic [31:0] addr;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   logic [31:0] instr_w [3];
   logic        v_w     [3];
   logic        f_w     [3];
   logic        b_w     [3];

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] seq_q [$];

   always #5 clk = ~clk;

   imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_l2 (
      .clk(clk), .a_rst(a_rst), .req(req), .addr(addr),
      .instr(instr_w[0]), .instr_valid(v_w[0]), .fault(f_w[0]), .busy(b_w[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   imem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_l0 (
      .clk(clk), .a_rst(a_rst), .req(req), .addr(addr),
      .instr(instr_w[1]), .instr_valid(v_w[1]), .fault(f_w[1]), .busy(b_w[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   imem_responder #(.DEPTH(DEPTH), .LATENCY(5)) dut_l5 (
      .clk(clk), .a_rst(a_rst), .req(req), .addr(addr),
      .instr(instr_w[2]), .instr_valid(v_w[2]), .fault(f_w[2]), .busy(b_w[2]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   function automatic int unsigned lat_of(input int sel);
      case (sel)
         0:       return 2;
         1:       return 0;
         default: return 5;
      endcase
   endfunction

   function automatic logic exp_fault(input logic [31:0] a);
      return (a % 4 != 0) || (64'(a) >= 64'(DEPTH) * 4);
   endfunction

   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      if (exp_fault(a)) return NOP;
      return mem_m[a / 4];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      req   = 1'b0;
      wr_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      if (64'(a) < 64'(DEPTH) * 4) mem_m[a / 4] = d;
   endtask

   // Runs the fetches in seq_q back-to-back on instance sel; optional write to
   // the fetched word on the response edge, optional addr change during WAIT.
   task automatic fetch_seq(input int sel, input bit do_wf, input logic [31:0] wf_data,
                            input bit do_chg);
      int unsigned lat;
      int          n;
      logic [31:0] a;
      logic [31:0] ei;
      lat = lat_of(sel);
      n   = seq_q.size();
      idle(12);
      req  = 1'b1;
      addr = seq_q[0];
      for (int i = 0; i < n; i++) begin
         a  = seq_q[i];
         ei = do_wf ? wf_data : exp_instr(a);
         @(posedge clk);
         for (int unsigned k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            check("busy_in_fetch", 32'(b_w[sel]), 32'd1);
            if (k < lat + 2) begin
               check("valid_early", 32'(v_w[sel]), 32'd0);
            end else begin
               check("valid_pulse", 32'(v_w[sel]), 32'd1);
               check("instr", instr_w[sel], ei);
               check("fault", 32'(f_w[sel]), 32'(exp_fault(a)));
            end
            if (do_chg && k == 1) addr = 32'h20;
            if (do_wf && k == lat + 1) begin
               wr_en   = 1'b1;
               wr_addr = a;
               wr_data = wf_data;
            end
            if (k == lat + 2) begin
               if (wr_en) begin
                  wr_en = 1'b0;
                  mem_m[a / 4] = wf_data;
               end
               if (i + 1 < n) addr = seq_q[i + 1];
               else req = 1'b0;
            end
         end
      end
      @(negedge clk);
      check("valid_after", 32'(v_w[sel]), 32'd0);
      check("busy_after", 32'(b_w[sel]), 32'd0);
   endtask

   initial begin
      int          sel;
      int          r;
      int          n;
      logic [31:0] a;
      a_rst   = 1'b0;
      req     = 1'b0;
      addr    = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      @(negedge clk);

      // program load while held in reset
      for (int unsigned w = 0; w < DEPTH; w++) wr(32'(w * 4), $urandom);
      wr(32'h0, 32'h0050_0093);
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("rst_instr", instr_w[s], NOP);
         check("rst_valid", 32'(v_w[s]), 32'd0);
         check("rst_busy", 32'(b_w[s]), 32'd0);
         check("rst_fault", 32'(f_w[s]), 32'd0);
      end
      a_rst = 1'b1;
      idle(2);

      seq_q = '{32'h0};
      fetch_seq(0, 1'b0, '0, 1'b0);

      seq_q = '{32'h4, 32'h8, 32'hC};
      fetch_seq(1, 1'b0, '0, 1'b0);

      seq_q = '{32'h6};        fetch_seq(0, 1'b0, '0, 1'b0);
      seq_q = '{32'h400};      fetch_seq(0, 1'b0, '0, 1'b0);
      seq_q = '{32'h8000_0000}; fetch_seq(1, 1'b0, '0, 1'b0);

      seq_q = '{32'h10};
      fetch_seq(0, 1'b1, 32'hDEAD_BEEF, 1'b0);

      wr(32'h400, 32'hBAD0_BAD0);
      wr(32'h8000_0000, 32'hBAD1_BAD1);
      seq_q = '{32'h0};
      fetch_seq(0, 1'b0, '0, 1'b0);

      seq_q = '{32'h0};
      fetch_seq(0, 1'b0, '0, 1'b1);

      // reset lands on the third WAIT cycle of a LATENCY=5 fetch
      idle(12);
      req  = 1'b1;
      addr = 32'h4;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("abort_valid_pre", 32'(v_w[2]), 32'd0);
      end
      a_rst = 1'b0;
      req   = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         check("abort_valid", 32'(v_w[2]), 32'd0);
         check("abort_instr", instr_w[2], NOP);
         check("abort_busy", 32'(b_w[2]), 32'd0);
         check("abort_fault", 32'(f_w[2]), 32'd0);
         if (j == 1) a_rst = 1'b1;
      end
      seq_q = '{32'h4};
      fetch_seq(2, 1'b0, '0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 2);
         n   = $urandom_range(1, 3);
         seq_q.delete();
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (r == 6) a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            else if (r == 7) a = 32'h400 + {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else             a = $urandom;
            seq_q.push_back(a);
         end
         if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 2 * DEPTH * 4 - 1), $urandom);
         if (n == 1 && $urandom_range(0, 3) == 0) begin
            seq_q[0] = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            fetch_seq(sel, 1'b1, $urandom, 1'b0);
         end else begin
            fetch_seq(sel, 1'b0, '0, 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
